// File: rtl/spell_mem_bridge.sv
// spell_mem_bridge: routes byte-wide CPU requests to an IO window, a local
// memory port or a Wishbone SRAM master, with a one-entry SRAM read buffer
// and a wait-cycle timeout.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   sram_enable                        memory goes to SRAM (1) or local port (0)
//   select/memory_type_data/write      request strobe, data/code space, write
//   addr, data_in                      request address and write data
//   data_out, data_ready, bus_error    read data, completion pulse, timeout flag
//   io_select, lm_select, sub_*        IO / local-memory request side
//   io_rdata/io_ready, lm_rdata/lm_ready  IO / local-memory responses
//   sram_*_o, sram_dat_i, sram_ack_i   Wishbone master
module spell_mem_bridge #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned BUS_BYTES   = 4,
  parameter int unsigned SRAM_ADDR_W = 10,
  parameter int unsigned IO_BASE     = 32'h20,
  parameter int unsigned IO_LIMIT    = 32'h60,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sram_enable,
  input  logic                     select,
  input  logic                     memory_type_data,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [7:0]               data_in,
  output logic [7:0]               data_out,
  output logic                     data_ready,
  output logic                     bus_error,
  output logic                     io_select,
  output logic                     lm_select,
  output logic [ADDR_W-1:0]        sub_addr,
  output logic [7:0]               sub_data,
  output logic                     sub_write,
  input  logic [7:0]               io_rdata,
  input  logic [7:0]               lm_rdata,
  input  logic                     io_ready,
  input  logic                     lm_ready,
  output logic                     sram_cyc_o,
  output logic                     sram_stb_o,
  output logic                     sram_we_o,
  output logic [BUS_BYTES-1:0]     sram_sel_o,
  output logic [SRAM_ADDR_W-1:0]   sram_addr_o,
  output logic [8*BUS_BYTES-1:0]   sram_dat_o,
  input  logic [8*BUS_BYTES-1:0]   sram_dat_i,
  input  logic                     sram_ack_i
);

  localparam int unsigned LB    = $clog2(BUS_BYTES);
  localparam int unsigned DW    = 8 * BUS_BYTES;
  localparam int unsigned TAG_W = ADDR_W - LB + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOCAL = 3'd1,
    ST_SRAM  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ARM   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic                   mtd_q, mtd_d;
  logic                   tgt_io_q, tgt_io_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   data_ready_q, data_ready_d;
  logic                   bus_error_q, bus_error_d;
  logic                   io_sel_q, io_sel_d;
  logic                   lm_sel_q, lm_sel_d;
  logic [ADDR_W-1:0]      sub_addr_q, sub_addr_d;
  logic [7:0]             sub_data_q, sub_data_d;
  logic                   sub_write_q, sub_write_d;
  logic                   cyc_q, cyc_d;
  logic                   stb_q, stb_d;
  logic                   we_q, we_d;
  logic [BUS_BYTES-1:0]   sel_q, sel_d;
  logic [SRAM_ADDR_W-1:0] saddr_q, saddr_d;
  logic [DW-1:0]          sdat_q, sdat_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]       buf_tag_q, buf_tag_d;
  logic [DW-1:0]          buf_data_q, buf_data_d;

  // Request decode on the live inputs (used only on the accepting edge)
  logic [31:0]      addr_ext_c;
  logic             is_io_c;
  logic [TAG_W-1:0] req_tag_c;
  logic [LB-1:0]    req_lane_c;
  logic             hit_c;
  // Fields of the latched request
  logic [TAG_W-1:0] lat_tag_c;
  logic [LB-1:0]    lat_lane_c;
  logic             timeout_c;
  logic             local_rdy_c;

  assign addr_ext_c  = 32'(addr);
  assign is_io_c     = memory_type_data && (addr_ext_c >= IO_BASE) && (addr_ext_c < IO_LIMIT);
  assign req_tag_c   = {memory_type_data, addr[ADDR_W-1:LB]};
  assign req_lane_c  = addr[LB-1:0];
  assign hit_c       = buf_valid_q && sram_enable && !write && !is_io_c && (buf_tag_q == req_tag_c);
  assign lat_tag_c   = {mtd_q, addr_q[ADDR_W-1:LB]};
  assign lat_lane_c  = addr_q[LB-1:0];
  assign timeout_c   = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign local_rdy_c = tgt_io_q ? io_ready : lm_ready;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    mtd_d        = mtd_q;
    tgt_io_d     = tgt_io_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_ready_d = 1'b0;
    bus_error_d  = bus_error_q;
    io_sel_d     = io_sel_q;
    lm_sel_d     = lm_sel_q;
    sub_addr_d   = sub_addr_q;
    sub_data_d   = sub_data_q;
    sub_write_d  = sub_write_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    sel_d        = sel_q;
    saddr_d      = saddr_q;
    sdat_d       = sdat_q;
    buf_valid_d  = buf_valid_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (select) begin
          addr_d      = addr;
          wdata_d     = data_in;
          write_d     = write;
          mtd_d       = memory_type_data;
          tgt_io_d    = is_io_c;
          cnt_d       = '0;
          bus_error_d = 1'b0;
          if (hit_c) begin
            // Buffer hit completes without touching the bus
            data_out_d   = buf_data_q[{req_lane_c, 3'b000} +: 8];
            data_ready_d = 1'b1;
            state_d      = ST_DONE;
          end else if (is_io_c || !sram_enable) begin
            io_sel_d    = is_io_c;
            lm_sel_d    = !is_io_c;
            sub_addr_d  = addr;
            sub_data_d  = data_in;
            sub_write_d = write;
            state_d     = ST_LOCAL;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = write;
            sel_d   = BUS_BYTES'(1) << req_lane_c;
            saddr_d = SRAM_ADDR_W'({memory_type_data, addr[ADDR_W-1:LB], {LB{1'b0}}});
            sdat_d  = {BUS_BYTES{data_in}};
            state_d = ST_SRAM;
          end
        end
      end

      ST_LOCAL: begin
        if (local_rdy_c) begin
          io_sel_d = 1'b0;
          lm_sel_d = 1'b0;
          if (!write_q) begin
            data_out_d = tgt_io_q ? io_rdata : lm_rdata;
          end
          data_ready_d = 1'b1;
          state_d      = ST_DONE;
        end else if (timeout_c) begin
          io_sel_d     = 1'b0;
          lm_sel_d     = 1'b0;
          data_out_d   = 8'hFF;
          bus_error_d  = 1'b1;
          data_ready_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SRAM: begin
        if (sram_ack_i) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          if (!write_q) begin
            data_out_d  = sram_dat_i[{lat_lane_c, 3'b000} +: 8];
            buf_valid_d = 1'b1;
            buf_tag_d   = lat_tag_c;
            buf_data_d  = sram_dat_i;
          end else if (buf_valid_q && (buf_tag_q == lat_tag_c)) begin
            // Keep the buffered word coherent with the written lane
            buf_data_d[{lat_lane_c, 3'b000} +: 8] = wdata_q;
          end
          data_ready_d = 1'b1;
          state_d      = ST_DONE;
        end else if (timeout_c) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          we_d         = 1'b0;
          data_out_d   = 8'hFF;
          bus_error_d  = 1'b1;
          data_ready_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_ARM;
      end

      ST_ARM: begin
        // Requester must drop select before a new request is taken
        if (!select) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Leaving SRAM mode makes the buffered word untrustworthy
    if (!sram_enable) begin
      buf_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      mtd_q        <= 1'b0;
      tgt_io_q     <= 1'b0;
      cnt_q        <= '0;
      data_out_q   <= 8'h00;
      data_ready_q <= 1'b0;
      bus_error_q  <= 1'b0;
      io_sel_q     <= 1'b0;
      lm_sel_q     <= 1'b0;
      sub_addr_q   <= '0;
      sub_data_q   <= '0;
      sub_write_q  <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      saddr_q      <= '0;
      sdat_q       <= '0;
      buf_valid_q  <= 1'b0;
      buf_tag_q    <= '0;
      buf_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      mtd_q        <= mtd_d;
      tgt_io_q     <= tgt_io_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
      bus_error_q  <= bus_error_d;
      io_sel_q     <= io_sel_d;
      lm_sel_q     <= lm_sel_d;
      sub_addr_q   <= sub_addr_d;
      sub_data_q   <= sub_data_d;
      sub_write_q  <= sub_write_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      saddr_q      <= saddr_d;
      sdat_q       <= sdat_d;
      buf_valid_q  <= buf_valid_d;
      buf_tag_q    <= buf_tag_d;
      buf_data_q   <= buf_data_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_ready  = data_ready_q;
  assign bus_error   = bus_error_q;
  assign io_select   = io_sel_q;
  assign lm_select   = lm_sel_q;
  assign sub_addr    = sub_addr_q;
  assign sub_data    = sub_data_q;
  assign sub_write   = sub_write_q;
  assign sram_cyc_o  = cyc_q;
  assign sram_stb_o  = stb_q;
  assign sram_we_o   = we_q;
  assign sram_sel_o  = sel_q;
  assign sram_addr_o = saddr_q;
  assign sram_dat_o  = sdat_q;

endmodule
